arith_rr_sched: RTL and testbench
=================================

// Module: arith_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one 16-bit saturating arithmetic unit (ADD, SUB, PADDSB)
//  between NUM_REQ requesters (pipeline ports, debug port, etc.). Per-requester valid/ready
//  request channels; one registered response channel tagged with requester id; sticky V/N/Z
//  flag register. Sits between the issue logic and the shared arithmetic datapath.
// PARAMETERS
//  NUM_REQ  4   requester count, 2..8
//  ID_W     2   response id width, >= clog2(NUM_REQ)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  req_valid  in   NUM_REQ      request i valid
//  req_ready  out  NUM_REQ      request i accepted this cycle (one-hot or zero)
//  req_a      in   16*NUM_REQ   operand A, slice i = [16i+15:16i]
//  req_b      in   16*NUM_REQ   operand B, same slicing
//  req_op     in   2*NUM_REQ    00 ADD, 10 SUB, x1 PADDSB
//  rsp_valid  out  1            response held in output register
//  rsp_ready  in   1            consumer accepts response
//  rsp_id     out  ID_W         index of originating requester
//  rsp_out    out  16           result
//  rsp_v/rsp_n/rsp_z  out 1 each  flags of this result
//  flags_vnz  out  3            {V,N,Z} of last response consumed (rsp_valid&rsp_ready)
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_id=0, rsp_out=0, rsp_v/n/z=0, flags_vnz=0, rr pointer=0, FSM=EMPTY.
//  FSM: EMPTY (no response held), FULL (response held). can_accept = EMPTY | (FULL & rsp_ready).
//  Arbitration: search from rr pointer upward, wrapping mod NUM_REQ; first req_valid wins.
//   req_ready[w]=can_accept for winner only; req_ready is combinational, does not depend on
//   rsp_valid of other requesters beyond can_accept.
//  On accept (req_valid[w]&req_ready[w]): next edge loads rsp_* from datapath, rsp_id=w,
//   FSM->FULL, rr pointer -> (w+1) mod NUM_REQ. Latency: exactly 1 cycle accept-to-rsp_valid.
//  FULL & rsp_ready & no accept -> EMPTY. FULL & rsp_ready & accept -> stays FULL, new data
//   (full throughput, 1 op/cycle). FULL & !rsp_ready -> all rsp_* stable, all req_ready=0.
//  flags_vnz updates only on rsp_valid&rsp_ready, with the consumed rsp_v/n/z.
//  No valid requests -> pointer unchanged. Requester may drop req_valid without penalty.
//  Arithmetic (16-bit two's complement):
//   ADD: s=A+B; SUB: s=A+~B+1. V = sign(A)==sign(B') && sign(s)!=sign(A), B'=B or ~B.
//   V=1 -> out=0x7FFF if sign(A)=0 else 0x8000; else out=s. Carry-out discarded.
//   PADDSB: per byte signed add, each byte saturates to 0x7F/0x80; V=0.
//   N=out[15], Z=(out==16'h0000), computed on the final (saturated) out for all ops.
//  Reset asserted mid-operation: held response discarded, outputs to reset values immediately.
// STRUCTURE
//  Package arith_pkg: op codes (OP_ADD=2'b00, OP_SUB=2'b10, PADDSB bit=op[0]), SAT_POS16=16'h7FFF,
//   SAT_NEG16=16'h8000, SAT_POS8=8'h7F, SAT_NEG8=8'h80.
//  Sub-module sat_alu16 (combinational: a,b,op -> out,v,n,z); one instance fed by granted mux.
//  Scheduler holds arbiter, operand mux, FSM and output/flag registers.
// TESTING
//  Reset: hold rst_n=0 -> rsp_valid=0, flags_vnz=0, req_ready=0; first grant after release to req 0.
//  Round robin: all 4 req_valid, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0, one rsp per cycle.
//  Saturation: ADD 0x7000+0x2000 -> 0x7FFF,V=1,N=0; SUB 0x8000-0x0001 -> 0x8000,V=1,N=1;
//   SUB 0x1234-0x1234 -> 0x0000,Z=1,V=0.
//  PADDSB: 0x7F80+0x01FF -> 0x7F80,V=0,N=0; 0x1020+0x0102 -> 0x1122.
//  Backpressure: rsp_ready=0 for 3 cycles with req 2 valid -> rsp_* stable, req_ready=0;
//   rsp_ready=1 -> req 2 accepted same cycle, flags_vnz updated next edge.
//  Async reset mid-FULL: rst_n low between edges -> rsp_valid drops without clock edge.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the round-robin arithmetic scheduler:
// op codes, saturation limits, the ALU result payload and the FSM encoding.
package arith_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned VNZ_W  = 3;

   localparam logic [OP_W-1:0] OP_ADD = 2'b00;
   localparam logic [OP_W-1:0] OP_SUB = 2'b10;
   // op[OP_PADDSB_BIT] set selects PADDSB regardless of op[1]
   localparam int unsigned OP_PADDSB_BIT = 0;
   localparam int unsigned OP_SUB_BIT    = 1;

   localparam logic [DATA_W-1:0] SAT_POS16 = 16'h7FFF;
   localparam logic [DATA_W-1:0] SAT_NEG16 = 16'h8000;
   localparam logic [BYTE_W-1:0] SAT_POS8  = 8'h7F;
   localparam logic [BYTE_W-1:0] SAT_NEG8  = 8'h80;

   typedef struct packed {
      logic [DATA_W-1:0] out;
      logic              v;
      logic              n;
      logic              z;
   } alu_rsp_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } sched_state_t;

   // Signed 8-bit add clamped to the byte range.
   function automatic logic [BYTE_W-1:0] sat_add8(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
      logic [BYTE_W:0] sum;
      sum = {a[BYTE_W-1], a} + {b[BYTE_W-1], b};
      if (sum[BYTE_W] != sum[BYTE_W-1]) begin
         return sum[BYTE_W] ? SAT_NEG8 : SAT_POS8;
      end
      return sum[BYTE_W-1:0];
   endfunction

endpackage

// File: rtl/sat_alu16.sv
// Combinational 16-bit saturating ALU: ADD, SUB, and per-byte signed saturating add.
module sat_alu16
   import arith_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] out,
   output logic              v,
   output logic              n,
   output logic              z
);

   logic [DATA_W-1:0] b_eff;
   logic [DATA_W-1:0] sum;
   logic              ovf;
   logic [DATA_W-1:0] res;
   logic              res_v;

   // SUB is A + ~B + 1; carry-out is dropped, overflow comes from the sign rule.
   always_comb begin
      b_eff = op[OP_SUB_BIT] ? ~b : b;
      sum   = a + b_eff + DATA_W'(op[OP_SUB_BIT]);
      ovf   = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
   end

   always_comb begin
      res   = sum;
      res_v = 1'b0;
      if (op[OP_PADDSB_BIT]) begin
         res = {sat_add8(a[DATA_W-1:BYTE_W], b[DATA_W-1:BYTE_W]),
                sat_add8(a[BYTE_W-1:0], b[BYTE_W-1:0])};
      end else if (ovf) begin
         res   = a[DATA_W-1] ? SAT_NEG16 : SAT_POS16;
         res_v = 1'b1;
      end
   end

   assign out = res;
   assign v   = res_v;
   assign n   = res[DATA_W-1];
   assign z   = (res == '0);

endmodule

// File: rtl/arith_rr_sched.sv
// Round-robin scheduler sharing one saturating ALU between NUM_REQ requesters,
// with a single registered response slot and a sticky V/N/Z flag register.
module arith_rr_sched
   import arith_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [DATA_W*NUM_REQ-1:0] req_a,
   input  logic [DATA_W*NUM_REQ-1:0] req_b,
   input  logic [OP_W*NUM_REQ-1:0]   req_op,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_out,
   output logic                      rsp_v,
   output logic                      rsp_n,
   output logic                      rsp_z,
   output logic [VNZ_W-1:0]          flags_vnz
);

   sched_state_t      state_q, state_nxt;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_nxt;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_nxt;
   alu_rsp_t          rsp_q, rsp_nxt;
   logic [VNZ_W-1:0]  flags_q, flags_nxt;

   logic [NUM_REQ-1:0] valid_rot;
   logic               grant_found;
   logic [ID_W-1:0]    grant_idx;
   int unsigned        slot;
   logic               can_accept;
   logic               accept;

   logic [DATA_W-1:0]  a_sel, b_sel;
   logic [OP_W-1:0]    op_sel;
   logic [DATA_W-1:0]  alu_out;
   logic               alu_v, alu_n, alu_z;
   alu_rsp_t           alu_res;

   // Rotate so bit k corresponds to requester (rr_ptr + k) mod NUM_REQ.
   assign valid_rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);

   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      slot        = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && valid_rot[k]) begin
            grant_found = 1'b1;
            slot        = 32'(rr_ptr_q) + k;
            if (slot >= NUM_REQ) begin
               slot = slot - NUM_REQ;
            end
            grant_idx = ID_W'(slot);
         end
      end
   end

   // Operand mux feeding the single shared ALU.
   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      op_sel = OP_ADD;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            a_sel  = req_a[DATA_W*i +: DATA_W];
            b_sel  = req_b[DATA_W*i +: DATA_W];
            op_sel = req_op[OP_W*i +: OP_W];
         end
      end
   end

   sat_alu16 u_alu (
      .a   (a_sel),
      .b   (b_sel),
      .op  (op_sel),
      .out (alu_out),
      .v   (alu_v),
      .n   (alu_n),
      .z   (alu_z)
   );

   always_comb begin
      alu_res.out = alu_out;
      alu_res.v   = alu_v;
      alu_res.n   = alu_n;
      alu_res.z   = alu_z;
   end

   // Next-state, response slot and handshake logic.
   always_comb begin
      state_nxt  = state_q;
      rr_ptr_nxt = rr_ptr_q;
      rsp_id_nxt = rsp_id_q;
      rsp_nxt    = rsp_q;
      flags_nxt  = flags_q;
      can_accept = 1'b0;
      accept     = 1'b0;
      req_ready  = '0;

      case (state_q)
         ST_EMPTY: begin
            can_accept = 1'b1;
         end
         ST_FULL: begin
            can_accept = rsp_ready;
            if (rsp_ready) begin
               flags_nxt = {rsp_q.v, rsp_q.n, rsp_q.z};
               state_nxt = ST_EMPTY;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase

      accept = can_accept && grant_found;
      if (accept) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
               req_ready[i] = 1'b1;
            end
         end
         state_nxt  = ST_FULL;
         rsp_nxt    = alu_res;
         rsp_id_nxt = grant_idx;
         rr_ptr_nxt = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_EMPTY;
         rr_ptr_q <= '0;
         rsp_id_q <= '0;
         rsp_q    <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_nxt;
         rr_ptr_q <= rr_ptr_nxt;
         rsp_id_q <= rsp_id_nxt;
         rsp_q    <= rsp_nxt;
         flags_q  <= flags_nxt;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_id    = rsp_id_q;
   assign rsp_out   = rsp_q.out;
   assign rsp_v     = rsp_q.v;
   assign rsp_n     = rsp_q.n;
   assign rsp_z     = rsp_q.z;
   assign flags_vnz = flags_q;

endmodule

// File: tb/tb_arith_rr_sched.sv
// Randomized self-checking bench for arith_rr_sched against an integer-arithmetic
// reference model, plus directed saturation, round-robin, backpressure and reset cases.
module tb_arith_rr_sched;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;

   logic                   clk;
   logic                   rst_n;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [16*NUM_REQ-1:0]  req_a;
   logic [16*NUM_REQ-1:0]  req_b;
   logic [2*NUM_REQ-1:0]   req_op;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [15:0]            rsp_out;
   logic                   rsp_v, rsp_n, rsp_z;
   logic [2:0]             flags_vnz;

   arith_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_out   (rsp_out),
      .rsp_v     (rsp_v),
      .rsp_n     (rsp_n),
      .rsp_z     (rsp_z),
      .flags_vnz (flags_vnz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state: what the scheduler is supposed to hold.
   int          m_ptr;
   bit          m_full;
   int          m_id;
   logic [18:0] m_rsp;     // {out[15:0], v, n, z}
   logic [2:0]  m_flags;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp(input int x, input int lo, input int hi);
      if (x < lo) return lo;
      if (x > hi) return hi;
      return x;
   endfunction

   // Saturating arithmetic from true signed sums; returns {out, v, n, z}.
   function automatic logic [18:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
      int          r, hi, lo;
      logic [15:0] o;
      logic        v;
      if (op[0]) begin
         hi = clamp(int'($signed(a[15:8])) + int'($signed(b[15:8])), -128, 127);
         lo = clamp(int'($signed(a[7:0])) + int'($signed(b[7:0])), -128, 127);
         o  = {8'(hi), 8'(lo)};
         v  = 1'b0;
      end else begin
         r = op[1] ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
         v = (r > 32767) || (r < -32768);
         o = 16'(clamp(r, -32768, 32767));
      end
      return {o, v, o[15], (o == 16'h0000)};
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_full  = 1'b0;
      m_id    = 0;
      m_rsp   = '0;
      m_flags = '0;
   endtask

   // Entered at a falling edge with requests already driven; checks, advances model, one cycle.
   task automatic step(input logic rdy);
      bit                 can;
      int                 win;
      int                 idx;
      logic [NUM_REQ-1:0] exp_rdy;
      rsp_ready = rdy;
      #1;
      can = !m_full || rdy;
      win = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (m_ptr + k) % NUM_REQ;
         if (win < 0 && req_valid[idx]) win = idx;
      end
      exp_rdy = '0;
      if (win >= 0 && can) exp_rdy[win] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, m_full);
      if (m_full) begin
         check("rsp_id", rsp_id, m_id);
         check("rsp_out", rsp_out, m_rsp[18:3]);
         check("rsp_vnz", {rsp_v, rsp_n, rsp_z}, m_rsp[2:0]);
      end
      check("flags_vnz", flags_vnz, m_flags);
      if (m_full && rdy) begin
         m_flags = m_rsp[2:0];
         m_full  = 1'b0;
      end
      if (win >= 0 && can) begin
         m_rsp  = ref_alu(req_a[16*win +: 16], req_b[16*win +: 16], req_op[2*win +: 2]);
         m_id   = win;
         m_full = 1'b1;
         m_ptr  = (win + 1) % NUM_REQ;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_op[2*i +: 2]  = op;
   endtask

   // Issue one op on requester i alone and compare the response with a fixed expectation.
   task automatic one_op(input string tag, input int i, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] op, input logic [18:0] exp);
      req_valid = '0;
      set_req(i, a, b, op);
      req_valid[i] = 1'b1;
      step(1'b1);
      req_valid = '0;
      check(tag, {rsp_out, rsp_v, rsp_n, rsp_z}, exp);
   endtask

   function automatic logic [15:0] pick_operand();
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 3))
         0: x[15:8] = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h80;
         1: x = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
         default: ;
      endcase
      return x;
   endfunction

   initial begin
      model_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_flags", flags_vnz, 3'b000);
      check("rst_req_ready", req_ready, '0);
      check("rst_rsp_out", rsp_out, 16'h0000);
      check("rst_rsp_id", rsp_id, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Round robin with everyone requesting: ids 0,1,2,3,0
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'($urandom), 16'($urandom), 2'($urandom));
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         step(1'b1);
         check("rr_seq", rsp_id, k % NUM_REQ);
         check("rr_valid", rsp_valid, 1'b1);
      end
      req_valid = '0;
      step(1'b1);

      // Saturation and PADDSB vectors; ordering sets up known flags for backpressure
      one_op("paddsb_1122", 0, 16'h1020, 16'h0102, 2'b11, {16'h1122, 3'b000});
      one_op("paddsb_sat", 0, 16'h7F80, 16'h01FF, 2'b01, {16'h7F80, 3'b000});
      one_op("sub_zero", 0, 16'h1234, 16'h1234, 2'b10, {16'h0000, 3'b001});
      one_op("add_sat", 0, 16'h7000, 16'h2000, 2'b00, {16'h7FFF, 3'b100});
      one_op("sub_sat", 0, 16'h8000, 16'h0001, 2'b10, {16'h8000, 3'b110});

      // Backpressure: response held, req 2 waiting
      set_req(2, 16'h0005, 16'h0003, 2'b00);
      req_valid = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         step(1'b0);
         check("bp_stable_out", rsp_out, 16'h8000);
         check("bp_no_ready", req_ready, '0);
         check("bp_flags_hold", flags_vnz, 3'b100);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_accept", req_ready, 4'b0100);
      step(1'b1);
      check("bp_flags_upd", flags_vnz, 3'b110);
      check("bp_new_rsp", {rsp_id, rsp_out}, {2'd2, 16'h0008});
      req_valid = '0;
      step(1'b1);

      // Asynchronous reset while a response is held
      set_req(1, 16'h0100, 16'h0200, 2'b00);
      req_valid = 4'b0010;
      step(1'b0);
      req_valid = '0;
      check("arst_pre", rsp_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", rsp_valid, 1'b0);
      check("arst_out", rsp_out, 16'h0000);
      check("arst_flags", flags_vnz, 3'b000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         req_valid = NUM_REQ'($urandom);
         for (int i = 0; i < NUM_REQ; i++) set_req(i, pick_operand(), pick_operand(), 2'($urandom));
         step($urandom_range(0, 3) != 0);
      end
      req_valid = '0;
      step(1'b1);
      step(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
